// File: rtl/hilo_muldiv_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide unit: operation launch,
// MTHI/MTLO writes, and the status/result outputs the forwarding mux reads.
interface hilo_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, rs, rt, mthi, mtlo, wdata,
    input  busy, done, div_by_zero, HI, LO
  );

  modport slave (
    input  start, op, rs, rt, mthi, mtlo, wdata,
    output busy, done, div_by_zero, HI, LO
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit owning the HI and LO registers.
// Works on operand magnitudes for 32 cycles, then sign-corrects and commits.
module hilo_muldiv_unit (
  input  logic         clk,
  input  logic         rst_n,
  hilo_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, ZDIV} state_t;

  state_t      state, next_state;
  logic [31:0] rem;       // multiply: product high half; divide: partial remainder
  logic [31:0] quo;       // multiply: multiplier shifting out; divide: dividend in, quotient out
  logic [31:0] opnd;      // multiplicand or divisor magnitude
  logic [4:0]  cnt;
  logic        is_div, neg_main, neg_rem;
  logic [31:0] hi_q, lo_q;
  logic        busy_q, done_q, dbz_q;

  logic        signed_op, sign_rs, sign_rt;
  logic [31:0] abs_rs, abs_rt;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix;

  assign signed_op = ~bus.op[0];
  assign sign_rs   = signed_op & bus.rs[31];
  assign sign_rt   = signed_op & bus.rt[31];
  assign abs_rs    = sign_rs ? -bus.rs : bus.rs;
  assign abs_rt    = sign_rt ? -bus.rt : bus.rt;

  assign mul_sum   = {1'b0, rem} + (quo[0] ? {1'b0, opnd} : 33'd0);
  assign div_shift = {rem, quo[31]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  // The true difference is below 2^32 whenever it is kept, so 32 bits suffice.
  assign div_diff  = div_shift[31:0] - opnd;

  assign prod_fix  = neg_main ? -{rem, quo} : {rem, quo};
  assign q_fix     = neg_main ? -quo : quo;
  assign r_fix     = neg_rem  ? -rem : rem;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = (bus.op[1] && bus.rt == 32'd0) ? ZDIV : RUN;
      RUN:     if (cnt == 5'd31) next_state = FIX;
      FIX:     next_state = IDLE;
      ZDIV:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every datapath register is reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      quo      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      busy_q <= (next_state == RUN) || (next_state == FIX);
      done_q <= (state == FIX) || (next_state == ZDIV);
      dbz_q  <= (next_state == ZDIV);

      case (state)
        IDLE: begin
          if (bus.mthi) hi_q <= bus.wdata;
          if (bus.mtlo) lo_q <= bus.wdata;
          if (next_state == RUN) begin
            is_div   <= bus.op[1];
            opnd     <= bus.op[1] ? abs_rt : abs_rs;
            quo      <= bus.op[1] ? abs_rs : abs_rt;
            rem      <= '0;
            cnt      <= '0;
            neg_main <= sign_rs ^ sign_rt;
            neg_rem  <= sign_rs;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            rem <= div_ge ? div_diff : div_shift[31:0];
            quo <= {quo[30:0], div_ge};
          end else begin
            rem <= mul_sum[32:1];
            quo <= {mul_sum[0], quo[31:1]};
          end
        end
        FIX: begin
          if (is_div) begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.HI          = hi_q;
  assign bus.LO          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized bench for hilo_muldiv_unit against an arithmetic
// HI/LO reference model.
module tb_hilo_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hilo_muldiv_if bus();

  hilo_muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int busy_total = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.busy === 1'b1) busy_total++;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_hi = '0, model_lo = '0;
  logic [31:0] exp_hi, exp_lo;
  int e0, busy_base;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // {HI, LO} as the architecture defines them, computed in 64-bit arithmetic.
  function automatic logic [63:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: r = 64'(sa * sb);
      2'd1: r = ua * ub;
      2'd2: begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      default: r = {32'(ua % ub), 32'(ua / ub)};
    endcase
    return r;
  endfunction

  task automatic mt_write(string tag, logic mh, logic ml, logic [31:0] wd);
    bus.mthi = mh; bus.mtlo = ml; bus.wdata = wd;
    @(posedge clk); #1;
    if (mh) model_hi = wd;
    if (ml) model_lo = wd;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check({tag, "_hi"}, bus.HI, model_hi);
    check({tag, "_lo"}, bus.LO, model_lo);
  endtask

  task automatic launch(string tag, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                        logic mh, logic ml, logic [31:0] wd, output logic zdiv);
    bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
    bus.mthi = mh; bus.mtlo = ml; bus.wdata = wd;
    zdiv = op[1] && (b == 32'd0);
    if (!zdiv) {exp_hi, exp_lo} = ref_result(op, a, b);
    @(posedge clk); #1;
    e0 = cyc;
    busy_base = busy_total;
    if (mh) model_hi = wd;
    if (ml) model_lo = wd;
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    bus.op = 2'($urandom); bus.rs = $urandom; bus.rt = $urandom;
    check({tag, "_done_e0"}, 32'(bus.done), 32'(zdiv));
    check({tag, "_hi_e0"}, bus.HI, model_hi);
    check({tag, "_lo_e0"}, bus.LO, model_lo);
  endtask

  task automatic finish_op(string tag);
    int guard = 0;
    logic hold_ok = 1'b1;
    while (bus.done !== 1'b1 && guard < 100) begin
      if (bus.HI !== model_hi || bus.LO !== model_lo) hold_ok = 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    model_hi = exp_hi;
    model_lo = exp_lo;
    check({tag, "_latency"}, cyc - e0, 33);
    check({tag, "_busy_cycles"}, busy_total - busy_base, 33);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
    check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_hi"}, bus.HI, model_hi);
    check({tag, "_lo"}, bus.LO, model_lo);
  endtask

  task automatic finish_zdiv(string tag);
    check({tag, "_dbz_e0"}, 32'(bus.div_by_zero), 32'd1);
    check({tag, "_busy_e0"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_e1"}, 32'(bus.done), 32'd0);
    check({tag, "_dbz_e1"}, 32'(bus.div_by_zero), 32'd0);
    check({tag, "_busy_e1"}, 32'(bus.busy), 32'd0);
    check({tag, "_hi"}, bus.HI, model_hi);
    check({tag, "_lo"}, bus.LO, model_lo);
  endtask

  task automatic run(string tag, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                     logic mh = 1'b0, logic ml = 1'b0, logic [31:0] wd = '0);
    logic zdiv;
    launch(tag, op, a, b, mh, ml, wd, zdiv);
    if (zdiv) finish_zdiv(tag);
    else      finish_op(tag);
  endtask

  initial begin
    logic zd;
    int dones, busys;
    bus.start = 1'b0; bus.op = '0; bus.rs = '0; bus.rt = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;

    #12;
    check("rst_hi", bus.HI, 32'h0);
    check("rst_lo", bus.LO, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_lit", bus.HI, 32'hFFFF_FFFE);
    check("multu_max_lo_lit", bus.LO, 32'h0000_0001);

    run("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_lo_lit", bus.LO, 32'hFFFF_FFEB);
    run("div_b2b", 2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_b2b_lo_lit", bus.LO, 32'hFFFF_FFFD);
    check("div_b2b_hi_lit", bus.HI, 32'hFFFF_FFFF);

    run("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_lit", bus.LO, 32'h8000_0000);
    check("div_ovf_hi_lit", bus.HI, 32'h0000_0000);
    run("divu_100_7", 2'd3, 32'd100, 32'd7);
    check("divu_100_7_lo_lit", bus.LO, 32'd14);
    check("divu_100_7_hi_lit", bus.HI, 32'd2);

    mt_write("pre_hi", 1'b1, 1'b0, 32'hAAAA_5555);
    run("divu_zero", 2'd3, 32'd100, 32'd0);
    check("divu_zero_hi_lit", bus.HI, 32'hAAAA_5555);

    // Writes and a second start while RUN is in progress must be ignored.
    launch("ignore", 2'd1, 32'd5, 32'd6, 1'b0, 1'b0, '0, zd);
    repeat (3) @(posedge clk);
    #1;
    bus.mthi = 1'b1; bus.wdata = 32'h1234_5678;
    bus.start = 1'b1; bus.op = 2'd2; bus.rs = 32'd9; bus.rt = 32'd0;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.start = 1'b0;
    check("ignore_hi_run", bus.HI, model_hi);
    finish_op("ignore");
    check("ignore_lo_lit", bus.LO, 32'd30);
    check("ignore_hi_lit", bus.HI, 32'd0);

    mt_write("mt_both", 1'b1, 1'b1, 32'hCAFE_F00D);
    run("start_mthi", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0BAD_BEEF);
    run("zdiv_mtlo", 2'd2, 32'd77, 32'd0, 1'b0, 1'b1, 32'h5EED_0001);

    // Asynchronous reset in the middle of RUN.
    mt_write("pre1", 1'b1, 1'b0, 32'd1);
    mt_write("pre2", 1'b0, 1'b1, 32'd2);
    launch("rst_run", 2'd1, 32'd5, 32'd6, 1'b0, 1'b0, '0, zd);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_hi = '0;
    model_lo = '0;
    check("rst_run_busy", 32'(bus.busy), 32'd0);
    check("rst_run_hi", bus.HI, 32'h0);
    check("rst_run_lo", bus.LO, 32'h0);
    check("rst_run_done", 32'(bus.done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0; busys = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
      if (bus.busy === 1'b1) busys++;
    end
    check("rst_run_no_done", dones, 0);
    check("rst_run_no_busy", busys, 0);
    check("rst_run_hi_after", bus.HI, 32'h0);
    run("after_rst", 2'd1, 32'd3, 32'd4);
    check("after_rst_lo_lit", bus.LO, 32'd12);

    for (int i = 0; i < 16; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 5);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      if (sel == 2) a = 32'h8000_0000;
      run($sformatf("rnd%0d", i), op, a, b,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide unit that owns the HI and LO architectural registers. It sits in the EX stage beside the ALU and consumes the rs/rt operand pair for MULT/MULTU/DIV/DIVU. It produces the HI and LO values that the second-operand selection mux forwards to the ALU for MFHI/MFLO. It also services MTHI/MTLO writes from the pipeline.

## Interface
Parameters:
- none; datapath fixed at 32 bits, 32 iterations.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs  in  32  multiplicand / dividend; sampled with start.
- rt  in  32  multiplier / divisor; sampled with start.
- mthi  in  1  write wdata to HI; honoured only in IDLE.
- mtlo  in  1  write wdata to LO; honoured only in IDLE.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  operation in progress; pipeline stalls while high.
- done  out  1  one-cycle pulse; result committed.
- div_by_zero  out  1  one-cycle pulse with done when a DIV/DIVU divisor is 0.
- HI  out  32  HI register.
- LO  out  32  LO register.

## Operation
- States:
  - IDLE:
    - start=1 with op DIV/DIVU and rt=0: go to ZDIV.
    - start=1 otherwise: latch |rs| and |rt| (signed ops) or raw values (unsigned ops), latch result sign(s), clear the iteration counter, go to RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. The 5-bit counter runs 0..31. After the step taken with counter=31, go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse done, go to IDLE.
  - ZDIV: pulse done and div_by_zero, leave HI/LO unchanged, go to IDLE.
- Multiply: the 64-bit product goes to {HI, LO}.
  - Signed: negate the product when the operand signs differ.
- Divide: quotient goes to LO, remainder to HI.
  - Signed: the quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) yields LO=0x80000000, HI=0 by natural 32-bit wrap; no flag.
- MTHI/MTLO:
  - In IDLE, HI or LO loads wdata on the next edge. mthi and mtlo together write both.
  - In any other state they are ignored.
- start in IDLE together with mthi/mtlo: the write occurs and the operation is launched. The operation result later overwrites HI/LO.
- start outside IDLE is ignored.
- rs/rt/op changes after the start edge have no effect.
- Reset (any state, including mid-RUN):
  - state IDLE; HI=0, LO=0.
  - busy=0, done=0, div_by_zero=0.
  - All internal operand, accumulator and counter registers are cleared.
  - No partial result is ever committed.

## Timing
- All outputs are registered.
- Reset values: HI=0x00000000, LO=0x00000000, busy=0, done=0, div_by_zero=0.
- Edge E0 samples start (normal op):
  - busy=1 from after E0 through after E32 (33 cycles).
  - RUN iterations on E1..E32.
  - FIX commit on E33. After E33: HI/LO hold the new values, done=1 for exactly one cycle, busy=0.
  - Total latency: 33 edges from the start edge to a valid result.
  - A back-to-back start is accepted on E34 at the earliest, i.e. the cycle done is high. IDLE samples start again there.
- Divide by zero: after E0, done=1 and div_by_zero=1 for one cycle; busy never asserts.
- HI/LO hold their old values throughout RUN, so MFHI/MFLO forwarding stays stable until the commit.

## Test plan
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> after E33: HI=0xFFFFFFFE, LO=0x00000001, done one cycle, busy high exactly 33 cycles.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV rs=0xFFFFFFF9 (-7) rt=2 launched the cycle done is high -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=0x80000000 rt=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, div_by_zero=0. DIVU rs=100 rt=7 -> LO=14, HI=2.
- Preload HI=0xAAAA5555 via mthi. Then DIVU rs=100 rt=0 -> done and div_by_zero pulse the cycle after start; HI=0xAAAA5555 and LO unchanged; busy stays 0.
- Launch MULTU 5*6. During RUN assert mthi wdata=0x12345678 and start with op=DIV -> both ignored; result HI=0, LO=30.
- Launch MULTU 5*6 with HI/LO preloaded to 1/2. Pull rst_n low at RUN cycle 10 (asynchronous, mid-cycle) -> immediately busy=0, HI=0, LO=0. After release, no done pulse appears, and a new MULTU 3*4 yields LO=12 at the nominal latency.
